// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin between core (m0) and debug (m1),
// bounded locked bursts, and one-cycle read-return steering to the owner.
//
// state  | meaning
// IDLE   | no ownership held; plain round-robin arbitration
// OWN0   | m0 holds the bus for a locked burst
// OWN1   | m1 holds the bus for a locked burst
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam logic [4:0] LP_MAX_BURST = 5'(MAX_BURST);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_pending;
  logic        r_pend_owner;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic        w_hold;
  logic        w_lock_sel;
  logic        w_we_sel;
  logic [4:0]  w_burst;

  // Arbitration; outputs are gated while reset is held so nothing leaks to memory.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_hold = 1'b0;
    if (reset) begin
      if (r_state == S_OWN0 && m0_req) begin
        w_gnt0 = 1'b1;
        w_hold = 1'b1;
      end else if (r_state == S_OWN1 && m1_req) begin
        w_gnt1 = 1'b1;
        w_hold = 1'b1;
      end else if (m0_req && m1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_lock_sel = w_gnt0 ? m0_lock : m1_lock;
  assign w_we_sel   = w_gnt0 ? m0_we : m1_we;
  // A grant that switches owner starts a fresh burst count.
  assign w_burst    = w_hold ? ({1'b0, r_cnt} + 5'd1) : 5'd1;

  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = 4'd0;
    w_last_nxt  = r_last;
    if (w_any_gnt) begin
      w_last_nxt = w_gnt1;
      if (w_lock_sel && (w_burst < LP_MAX_BURST)) begin
        w_state_nxt = w_gnt0 ? S_OWN0 : S_OWN1;
        w_cnt_nxt   = w_burst[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_cnt        <= 4'd0;
      r_pending    <= 1'b0;
      r_pend_owner <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_any_gnt & ~w_we_sel;
      r_pend_owner <= w_gnt1;
    end
  end

  always_comb begin
    mem_en    = w_any_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_pending & ~r_pend_owner;
  assign m1_rvalid = r_pending & r_pend_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level ownership/round-robin model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 1; m0_addr = 32'h44; m0_wdata = 32'h55;
    m1_req = 1; m1_addr = 32'h66; m1_wdata = 32'h77;
    mem_rdata = 32'hA5A5A5A5;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin
        n_errors++; $display("FAIL rst_gnt: got %b expected 00", {m0_gnt, m1_gnt});
      end
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
        n_errors++; $display("FAIL rst_mem: en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      n_checks++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
        n_errors++; $display("FAIL rst_rd: rv=%b%b rd0=%h rd1=%h expected all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      end
      next_cycle();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10}) begin
      n_errors++; $display("FAIL rd_beat: gnt=%b%b en=%b we=%b addr=%h expected gnt=10 en=1 we=0 addr=10", m0_gnt, m1_gnt, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    m0_req = 0; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_errors++; $display("FAIL rd_return: rv=%b%b rd0=%h expected rv=10 rd0=deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== '0) begin
      n_errors++; $display("FAIL rd_oneshot: rv=%b%b rd0=%h expected all 0", m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_burst_limit();
    int seq [6] = '{0, 0, 0, 0, 1, 0};
    logic [1:0] exp;
    do_reset();
    m0_req = 1; m0_lock = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int i = 0; i < 6; i++) begin
      exp = (seq[i] == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    m0_addr = 32'hFFFF; m0_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 32'h20, 32'h12345678}) begin
      n_errors++; $display("FAIL wr_beat: gnt=%b%b en=%b we=%b addr=%h wdata=%h expected 01 1 1 20 12345678", m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    m1_req = 0; m1_addr = 32'h99; mem_rdata = 32'h13572468;
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_errors++; $display("FAIL wr_no_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_errors++; $display("FAIL nogrant_mem: en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_lock_release();
    do_reset();
    m0_req = 1; m0_lock = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) m0_lock = 0;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL lockrel_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, (i == 3) ? 2'b01 : 2'b10);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_discard();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_errors++; $display("FAIL disc_gnt: got %b expected 01", {m0_gnt, m1_gnt});
    end
    next_cycle();
    reset = 1'b0; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m1_rdata} !== '0) begin
      n_errors++; $display("FAIL disc_rvalid: rv1=%b rd1=%h expected 0", m1_rvalid, m1_rdata);
    end
    next_cycle();
    reset = 1'b1;
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 4'b0010) begin
      n_errors++; $display("FAIL disc_after: rv=%b%b gnt=%b%b expected rv=00 gnt=10", m0_rvalid, m1_rvalid, m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Model: owner (-1 none), beats taken in the current ownership, last winner,
  // and which master (-1 none) a read was granted to in the previous cycle.
  task automatic test_random();
    logic          rq [2], lk [2], we [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] rd_val;
    logic [1:0]    exp_gnt, exp_rv;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rd0, exp_rd1;
    int owner, beats, last, prev_rd, g;
    bit cont, rst_cyc;
    do_reset();
    owner = -1; beats = 0; last = 1; prev_rd = -1;
    for (int c = 0; c < 400; c++) begin
      rst_cyc = ($urandom_range(0, 39) == 0);
      for (int m = 0; m < 2; m++) begin
        rq[m] = ($urandom_range(0, 3) != 0);
        lk[m] = $urandom_range(0, 1) == 1;
        we[m] = $urandom_range(0, 1) == 1;
        ad[m] = $urandom;
        wd[m] = $urandom;
      end
      rd_val = $urandom;
      m0_req = rq[0]; m0_lock = lk[0]; m0_we = we[0]; m0_addr = ad[0]; m0_wdata = wd[0];
      m1_req = rq[1]; m1_lock = lk[1]; m1_we = we[1]; m1_addr = ad[1]; m1_wdata = wd[1];
      mem_rdata = rd_val;
      reset = rst_cyc ? 1'b0 : 1'b1;

      g = -1; cont = 0;
      if (!rst_cyc) begin
        if (owner >= 0 && rq[owner]) begin g = owner; cont = 1; end
        else if (rq[0] && rq[1]) g = 1 - last;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
      end
      exp_gnt   = {g == 0, g == 1};
      exp_we    = (g >= 0) ? we[g] : 1'b0;
      exp_addr  = (g >= 0) ? ad[g] : '0;
      exp_wdata = (g >= 0) ? wd[g] : '0;
      exp_rv    = rst_cyc ? 2'b00 : {prev_rd == 0, prev_rd == 1};
      exp_rd0   = exp_rv[1] ? rd_val : '0;
      exp_rd1   = exp_rv[0] ? rd_val : '0;

      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp_gnt) begin
        n_errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {m0_gnt, m1_gnt}, exp_gnt);
      end
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {g >= 0, exp_we, exp_addr, exp_wdata}) begin
        n_errors++; $display("FAIL rnd_mem[%0d]: en=%b we=%b addr=%h wd=%h expected en=%b we=%b addr=%h wd=%h", c, mem_en, mem_we, mem_addr, mem_wdata, g >= 0, exp_we, exp_addr, exp_wdata);
      end
      n_checks++;
      if ({m0_rvalid, m1_rvalid} !== exp_rv) begin
        n_errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, {m0_rvalid, m1_rvalid}, exp_rv);
      end
      n_checks++;
      if ({m0_rdata, m1_rdata} !== {exp_rd0, exp_rd1}) begin
        n_errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", c, m0_rdata, m1_rdata, exp_rd0, exp_rd1);
      end

      if (rst_cyc) begin
        owner = -1; beats = 0; last = 1; prev_rd = -1;
      end else begin
        prev_rd = (g >= 0 && !we[g]) ? g : -1;
        if (g >= 0) begin
          last  = g;
          beats = cont ? beats + 1 : 1;
          if (lk[g] && beats < MB) owner = g;
          else begin owner = -1; beats = 0; end
        end else begin
          owner = -1; beats = 0;
        end
      end
      next_cycle();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_limit();
    test_write();
    test_lock_release();
    test_reset_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
